// File: rtl/gate_bist_pkg.sv
// Shared state encoding and truth-table constants for the 2-input gate self-test sequencer.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit i is the gate output for {A,B} == i.
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;

endpackage

// File: rtl/gate_bist_timer.sv
// Hold counter for one test vector: counts 0..HOLD_CYCLES-1 while enabled, wraps on terminal count.
// Single-cycle terminal count (tc_o) is combinational from the registered count; no backpressure.
module gate_bist_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == CNT_W'(HOLD_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for a 2-input gate: walks {A,B} through 00..11, LOOPS times, HOLD_CYCLES each,
// and scores the sampled Y against EXPECT. busy lasts 4*LOOPS*HOLD_CYCLES cycles; start ignored while busy.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int         HOLD_CYCLES = 4,
  parameter int         LOOPS       = 1,
  parameter logic [3:0] EXPECT      = NAND_TT,
  parameter int         ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gate_y,
  output logic             gate_a,
  output logic             gate_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       fail_vec
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("gate_bist_ctrl: HOLD_CYCLES must be >= 1");
  end
  if (LOOPS < 1) begin : g_bad_loops
    $error("gate_bist_ctrl: LOOPS must be >= 1");
  end

  localparam int               LOOP_W  = $clog2(LOOPS) + 1;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e            state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [3:0]        fail_q, fail_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic timer_clr;
  logic timer_en;
  logic hold_tc;
  logic mismatch;
  logic last_vec;

  gate_bist_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tc_o  (hold_tc)
  );

  assign mismatch = (gate_y != EXPECT[vec_q]);
  assign last_vec = (vec_q == 2'd3) && (loop_q == LOOP_W'(LOOPS - 1));

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    loop_d    = loop_q;
    err_d     = err_q;
    fail_d    = fail_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timer_clr = 1'b0;
    timer_en  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_APPLY;
          vec_d     = 2'd0;
          loop_d    = '0;
          err_d     = '0;
          fail_d    = 4'b0000;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timer_clr = 1'b1;
        end
      end

      ST_APPLY: begin
        timer_en = 1'b1;
        if (hold_tc) begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + 1'b1;
            end
            fail_d[vec_q] = 1'b1;
          end
          // The last compare lands on the same edge that reports the result.
          if (last_vec) begin
            state_d = ST_DONE;
            vec_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + 2'd1;
            if (vec_q == 2'd3) begin
              loop_d = loop_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      loop_q  <= '0;
      err_q   <= '0;
      fail_q  <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      loop_q  <= loop_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign gate_a   = vec_q[1];
  assign gate_b   = vec_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: four parameterisations, each driving a behavioural gate given by a truth table.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start_s [4];
  logic [3:0] tt_q    [4];
  logic       ga      [4];
  logic       gb      [4];
  logic       gy      [4];
  logic       busy_w  [4];
  logic       done_w  [4];
  logic       pass_w  [4];
  logic [3:0] err_w   [4];
  logic [3:0] fv_w    [4];
  logic [3:0] err0, err1, err3;
  logic [1:0] err2;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_gate
    assign gy[i] = tt_q[i][{ga[i], gb[i]}];
  end

  assign err_w[0] = err0;
  assign err_w[1] = err1;
  assign err_w[2] = {2'b00, err2};
  assign err_w[3] = err3;

  gate_bist_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .gate_y(gy[0]),
    .gate_a(ga[0]), .gate_b(gb[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_cnt(err0), .fail_vec(fv_w[0])
  );

  gate_bist_ctrl #(.LOOPS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .gate_y(gy[1]),
    .gate_a(ga[1]), .gate_b(gb[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_cnt(err1), .fail_vec(fv_w[1])
  );

  gate_bist_ctrl #(.LOOPS(2), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .gate_y(gy[2]),
    .gate_a(ga[2]), .gate_b(gb[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .err_cnt(err2), .fail_vec(fv_w[2])
  );

  gate_bist_ctrl #(.HOLD_CYCLES(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .gate_y(gy[3]),
    .gate_a(ga[3]), .gate_b(gb[3]), .busy(busy_w[3]), .done(done_w[3]),
    .pass(pass_w[3]), .err_cnt(err3), .fail_vec(fv_w[3])
  );

  function automatic int hold_of(input int d);
    return (d == 3) ? 1 : 4;
  endfunction

  function automatic int loops_of(input int d);
    return (d == 1 || d == 2) ? 2 : 1;
  endfunction

  function automatic int errmax_of(input int d);
    return (d == 2) ? 3 : 15;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input int d, input string tag);
    chk(tag, {20'd0, ga[d], gb[d], busy_w[d], done_w[d], pass_w[d], err_w[d], fv_w[d]}, 32'd0);
  endtask

  // One run on DUT d with the gate behaving as truth table tt; called and returning on a falling edge.
  task automatic run_check(input int d, input logic [3:0] tt, input int delay,
                           input int repulse, input string tag);
    int         h;
    int         l;
    int         k;
    int         exp_busy;
    int         exp_err;
    logic [3:0] diff;
    h        = hold_of(d);
    l        = loops_of(d);
    exp_busy = 4 * h * l;
    tt_q[d]  = tt;
    repeat (delay) @(negedge clk);
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    chk({tag, "/clear"}, {done_w[d], pass_w[d], err_w[d], fv_w[d]}, 32'd0);
    k = 0;
    while (busy_w[d] === 1'b1 && k <= exp_busy + 8) begin
      chk({tag, "/vec"}, {30'd0, ga[d], gb[d]}, 32'((k / h) % 4));
      start_s[d] = (k == repulse);
      k++;
      @(negedge clk);
    end
    start_s[d] = 1'b0;
    chk({tag, "/busy_cycles"}, k, exp_busy);

    diff    = tt ^ NAND_TT;
    exp_err = l * $countones(diff);
    if (exp_err > errmax_of(d)) exp_err = errmax_of(d);
    chk({tag, "/done"}, done_w[d], 1);
    chk({tag, "/pass"}, pass_w[d], (diff == 4'b0000) ? 1 : 0);
    chk({tag, "/err_cnt"}, err_w[d], exp_err);
    chk({tag, "/fail_vec"}, fv_w[d], diff);
    chk({tag, "/ab_idle"}, {ga[d], gb[d]}, 0);
  endtask

  initial begin
    logic [3:0] rtt;
    int         rd;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      tt_q[i]    = NAND_TT;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk_all_zero(i, $sformatf("reset_state%0d", i));

    run_check(0, NAND_TT, 0, -1, "t1_nand");
    run_check(0, 4'b1111, 1, -1, "t2_tie1");
    run_check(1, 4'b0000, 0, -1, "t3_tie0_l2");
    run_check(2, 4'b0000, 0, -1, "t4_sat");
    run_check(0, NAND_TT, 2, 5, "t5_repulse");

    // Reset asserted while vector 2 is on the gate.
    tt_q[0]    = NAND_TT;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (9) @(negedge clk);
    chk("t5_pre_rst_vec", {ga[0], gb[0]}, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero(0, "t5_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero(0, "t5_post_rst");
    run_check(0, NAND_TT, 0, -1, "t5_after_rst");

    run_check(3, 4'b0000, 0, -1, "t6_bad");
    run_check(3, NAND_TT, 0, -1, "t6_restart");
    run_check(3, NAND_TT, 0, -1, "t6_restart2");
    run_check(3, XOR_TT, 0, -1, "t6_xor");

    for (int it = 0; it < 40; it++) begin
      rd  = int'($urandom_range(0, 3));
      rtt = 4'($urandom);
      run_check(rd, rtt, int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 31)) : -1,
                $sformatf("rand%0d_d%0d_tt%0h", it, rd, rtt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
